// File: rtl/adder_tree_8x7.sv
// adder_tree_8x7 -- pipelined eight-operand unsigned adder with carry-in.
//
// Sums a..h plus ci as a three-level binary tree of ripple-carry adders
// (8 -> 4 -> 2 -> 1). The result is {co, s} = total[WIDTH:0]. Bits above
// WIDTH are dropped, so large totals wrap.
//
// Configuration macro: ADDER_TREE_PIPE_EN
//   undefined : stage 1 = L1 partial sums, stage 2 = {co,s}; latency 2
//   defined   : an extra bank holds the L2 sums before L3;   latency 3
// Arithmetic is identical in both builds. Throughput is one result per cycle,
// and there is no handshake or stall.

// Ripple-carry adder built from explicit full-adder cells.
// Produces an N+1 bit sum. The top bit is the final carry.
module adder_tree_8x7_rca #(
  parameter int N = 7
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N:0]   sum
);

  // Carry chain; c[i] is the carry into bit i.
  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    // Full-adder cell: sum bit and carry to the next position.
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign sum[N] = c[N];

endmodule

module adder_tree_8x7 #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  // ---------------------------------------------------------------------
  // Level 1: four pairwise sums. The carry-in enters at the LSB of p0, so
  // the +1 costs no extra adder.
  // ---------------------------------------------------------------------
  logic [WIDTH:0] p0_d, p1_d, p2_d, p3_d;
  logic [WIDTH:0] p0_q, p1_q, p2_q, p3_q;

  adder_tree_8x7_rca #(.N(WIDTH)) u_l1_p0 (.x(a), .y(b), .cin(ci),   .sum(p0_d));
  adder_tree_8x7_rca #(.N(WIDTH)) u_l1_p1 (.x(c), .y(d), .cin(1'b0), .sum(p1_d));
  adder_tree_8x7_rca #(.N(WIDTH)) u_l1_p2 (.x(e), .y(f), .cin(1'b0), .sum(p2_d));
  adder_tree_8x7_rca #(.N(WIDTH)) u_l1_p3 (.x(g), .y(h), .cin(1'b0), .sum(p3_d));

  // Stage 1: register the four level-1 partial sums.
  always_ff @(posedge clk) begin
    // NOTE: pipeline state is cleared synchronously. Reset flushes every
    // in-flight sum so none can re-emerge once rst drops.
    if (rst) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every stage sampling the
      // previous-cycle value of its predecessor.
      p0_q <= p0_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      p3_q <= p3_d;
    end
  end

  // ---------------------------------------------------------------------
  // Level 2: two sums of the registered partials, each WIDTH+2 bits.
  // ---------------------------------------------------------------------
  logic [WIDTH+1:0] q0_d, q1_d;
  logic [WIDTH+1:0] q0_l3, q1_l3;   // level-2 values as seen by level 3

  adder_tree_8x7_rca #(.N(WIDTH + 1)) u_l2_q0 (.x(p0_q), .y(p1_q), .cin(1'b0), .sum(q0_d));
  adder_tree_8x7_rca #(.N(WIDTH + 1)) u_l2_q1 (.x(p2_q), .y(p3_q), .cin(1'b0), .sum(q1_d));

`ifdef ADDER_TREE_PIPE_EN
  logic [WIDTH+1:0] q0_q, q1_q;

  // Optional bank between L2 and L3. It shortens the combinational path and
  // adds one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      q0_q <= '0;
      q1_q <= '0;
    end else begin
      q0_q <= q0_d;
      q1_q <= q1_d;
    end
  end

  assign q0_l3 = q0_q;
  assign q1_l3 = q1_q;
`else
  assign q0_l3 = q0_d;
  assign q1_l3 = q1_d;
`endif

  // ---------------------------------------------------------------------
  // Level 3: final sum at full precision (WIDTH+3 bits).
  // ---------------------------------------------------------------------
  logic [WIDTH+2:0] r;
  logic [WIDTH:0]   sum_q;

  adder_tree_8x7_rca #(.N(WIDTH + 2)) u_l3_r (.x(q0_l3), .y(q1_l3), .cin(1'b0), .sum(r));

  // Bits above WIDTH are the deliberately discarded wrap portion of the total.
  logic unused_r_hi;
  assign unused_r_hi = ^r[WIDTH+2:WIDTH+1];

  // Stage 2: register {co, s} from the low WIDTH+1 bits of the total.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= r[WIDTH:0];
    end
  end

  assign s  = sum_q[WIDTH-1:0];
  assign co = sum_q[WIDTH];

endmodule

// File: tb/tb_adder_tree_8x7.sv
// tb_adder_tree_8x7 -- directed self-checking bench for adder_tree_8x7.
// Latency follows ADDER_TREE_PIPE_EN: 3 when defined, 2 otherwise.
`timescale 1ns/1ps
module tb_adder_tree_8x7;

`ifdef ADDER_TREE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int NV = 9;

  logic       clk;
  logic       rst;
  logic [6:0] a, b, c, d, e, f, g, h;
  logic       ci;
  logic [6:0] s;
  logic       co;

  int total = 0;
  int bad   = 0;

  // Directed vectors: operands a..h, carry-in, and hand-computed {co,s}.
  logic [6:0] ops  [NV][8];
  logic       cis  [NV];
  logic [7:0] exps [NV];

  adder_tree_8x7 #(.WIDTH(7)) dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .ci(ci), .s(s), .co(co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got {co,s}=%0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic put(input int idx,
                     input int va, input int vb, input int vc, input int vd,
                     input int ve, input int vf, input int vg, input int vh,
                     input logic vci, input int expv);
    ops[idx][0] = 7'(va); ops[idx][1] = 7'(vb);
    ops[idx][2] = 7'(vc); ops[idx][3] = 7'(vd);
    ops[idx][4] = 7'(ve); ops[idx][5] = 7'(vf);
    ops[idx][6] = 7'(vg); ops[idx][7] = 7'(vh);
    cis[idx]    = vci;
    exps[idx]   = 8'(expv);
  endtask

  task automatic apply(input int idx);
    a = ops[idx][0]; b = ops[idx][1]; c = ops[idx][2]; d = ops[idx][3];
    e = ops[idx][4]; f = ops[idx][5]; g = ops[idx][6]; h = ops[idx][7];
    ci = cis[idx];
  endtask

  task automatic apply_zero();
    a = '0; b = '0; c = '0; d = '0; e = '0; f = '0; g = '0; h = '0;
    ci = 1'b0;
  endtask

  // Advance one rising edge and settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    put(0,  1,  1,  1,  1,  1,  1,  1,  1, 1'b0,   8);
    put(1,  1,  2,  3,  4,  5,  6,  7,  8, 1'b0,  36);
    put(2,  1,  2,  3,  4,  5,  6,  7,  8, 1'b1,  37);
    put(3, 15, 15, 15, 15, 15, 15, 15, 15, 1'b0, 120);
    put(4, 10, 14, 15,  0,  4,  6,  9, 13, 1'b0,  71);
    put(5, 16, 15, 15, 15, 15, 15, 15, 15, 1'b1, 122);
    put(6, 16, 16, 16, 16, 16, 16, 16, 15, 1'b1, 128);  // T=128: s=0, co=1
    put(7,  0,  0,  0,  0,  0,  0,  0,  0, 1'b1,   1);
    put(8, 127,127,127,127,127,127,127,127,1'b1, 249);  // T=1017: s=121, co=1

    // Reset state
    rst = 1'b1;
    apply_zero();
    @(negedge clk);
    step();
    step();
    check("reset", {co, s}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("reset_release_idle", {co, s}, 8'd0);

    // Latency: one vector, then zeros; the result appears exactly LAT edges later
    @(negedge clk);
    apply(0);
    for (int k = 1; k <= LAT; k++) begin
      step();
      apply_zero();
      check($sformatf("latency_edge%0d", k), {co, s}, (k == LAT) ? exps[0] : 8'd0);
    end

    // Back-to-back stream: vector i enters before edge i+1 and exits after edge i+LAT
    for (int ed = 1; ed <= NV + LAT - 1; ed++) begin
      @(negedge clk);
      if (ed - 1 < NV) apply(ed - 1);
      else             apply_zero();
      step();
      if (ed >= LAT)
        check($sformatf("stream_vec%0d", ed - LAT), {co, s}, exps[ed - LAT]);
    end

    // Reset with data in flight
    @(negedge clk);
    apply(3);
    @(negedge clk);
    apply(4);
    @(negedge clk);
    apply(5);
    rst = 1'b1;
    step();
    check("flush_edge1", {co, s}, 8'd0);
    @(negedge clk);
    apply(6);
    step();
    check("flush_edge2", {co, s}, 8'd0);

    // Release: the first post-reset vector emerges at full latency and nothing earlier
    @(negedge clk);
    rst = 1'b0;
    apply(1);
    for (int k = 1; k <= LAT; k++) begin
      step();
      apply_zero();
      check($sformatf("post_reset_edge%0d", k), {co, s}, (k == LAT) ? exps[1] : 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
